id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised second-generation decode stage for the 16-bit pipelined CPU. It combines instruction decode, an internal 16-entry register file with WB write-through, branch resolution in ID, and hazard detection (load-use, flag, branch-register). It also owns the registered ID/EX pipeline boundary with stall, bubble and hold. It sits between the IF/ID register and EX.

Parameters:
DATA_W, 16, datapath/register/PC width; instruction stays 16 bits
BYPASS_EN, 1, 1 = WB write visible to same-cycle ID read; 0 = visible next cycle
HAZARD_EN, 1, 1 = internal hazard detection active; 0 = id_stall driven only by ex_hold

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_valid  in  1  IF/ID holds a real instruction
if_instr  in  16  instruction
if_pc_plus2  in  DATA_W  PC+2 of instruction
flags  in  3  {Z,V,N} from flag register
wb_we / wb_addr / wb_data  in  1/4/DATA_W  register write port
mem_rd_we / mem_rd  in  1/4  EX/MEM destination (BR hazard)
ex_hold  in  1  downstream stall; freeze ID/EX
id_stall  out  1  IF must hold PC and IF/ID
branch_taken  out  1  redirect IF, flush IF/ID
branch_target  out  DATA_W  redirect address
ex_valid, ex_opcode[3:0], ex_rs_data, ex_rt_data, ex_imm (DATA_W each), ex_rd/ex_rs/ex_rt[3:0], ex_mem_read, ex_mem_write, ex_reg_write, ex_alu_src, ex_flag_we, ex_pcs, ex_halt, ex_pc_plus2[DATA_W]  out  ID/EX register contents

Behaviour:
- Opcodes: ADD0 SUB1 XOR2 RED3 SLL4 SRA5 ROR6 PADDSB7 LW8 SW9 LLB A, LHB B, B C, BR D, PCS E, HLT F.
- Fields:
  - R-type: rd=[11:8], rs=[7:4], rt=[3:0].
  - LW/SW: rt=[11:8], rs=[7:4], imm=sext([3:0])<<1. SW reads rt; LW writes rt.
  - LLB/LHB: rd=rs=[11:8], imm=zext([7:0]).
  - Shifts: imm=zext([3:0]), alu_src=1.
  - PCS: rd=[11:8].
  - HLT: ex_halt=1.
- flag_we: ADD, SUB, XOR. reg_write: opcodes 0-7, 8, A, B, E; forced 0 when rd==0.
- Register file: R0 reads 0, writes to R0 ignored. BYPASS_EN=1: wb_addr matching a read address (non-zero) returns wb_data in the same cycle.
- Branch, condition [11:9]:
  - 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1
  - 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always
  - B target = pc_plus2 + (sext([8:0])<<1), width-truncated to DATA_W. BR target = reg[[7:4]].
  - branch_taken combinational; 0 when if_valid=0, id_stall=1 or rst.
- Hazards (HAZARD_EN=1; a hazard is any of the following):
  - ID/EX valid & mem_read & rd≠0 & rd equals a used source of the ID instruction.
  - ID/EX valid & flag_we & ID is B/BR with cond≠111.
  - ID is BR & [7:4]≠0 & matches ID/EX rd with reg_write, or mem_rd with mem_rd_we.
- id_stall = ex_hold | (if_valid & hazard).
- ID/EX update priority per clock:
  - rst: all ex_* outputs to 0.
  - else ex_hold: hold all values.
  - else hazard or !if_valid: bubble, ex_valid=0, all controls 0, data don't-care (driven 0).
  - else load the decoded instruction, ex_valid=1.
- Latency 1 cycle ID→EX. A taken branch itself enters ID/EX as a valid no-write entry.
- Reset mid-stall drops the bubble/held entry. The first cycle after reset accepts a new instruction.

Test Plan:
- Reset, then ADD R3,R1,R2 with R1=5, R2=7 preloaded via WB → next cycle ex_valid=1, ex_rs_data=5, ex_rt_data=7, ex_rd=3, ex_flag_we=1.
- LW R4,[R1+3] followed by ADD R5,R4,R2 → ex_imm=6; id_stall=1 for exactly 1 cycle, one bubble (ex_valid=0), then the ADD issues.
- SUB in ID/EX, then B cond=001 with Z=1 → 1-cycle stall, then branch_taken=1 with target=pc_plus2+2·I.
- WB writes R6=0x1234 in the same cycle ID reads R6: BYPASS_EN=1 gives 0x1234; BYPASS_EN=0 gives the old value.
- ex_hold=1 for 3 cycles with a valid entry → ex_* outputs constant, id_stall=1, branch_taken=0.
- rst asserted during a load-use stall → all ex_* outputs 0 next cycle; writing R0 via WB leaves R0 reading 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode stage of the 16-bit pipelined CPU.
// Decodes the IF/ID instruction and reads the internal register file, which
// has a WB write port. It resolves B/BR in ID and detects load-use, flag and
// branch-register hazards. It also owns the registered ID/EX boundary, which
// supports hold (ex_hold), bubble (hazard or empty IF/ID) and load.
// The width helpers below assume DATA_W >= 10.
// Field choices for operands the ISA leaves unused:
//   - ex_rd is always [11:8]. For LW it also names the written register (rt).
//   - ex_rt is [3:0] for opcodes 0-7, [11:8] for LW/SW, and R0 otherwise.
//   - ex_rs is [11:8] for LLB/LHB and [7:4] otherwise.
//   - ex_imm is 0 for opcodes that carry no immediate.

module id_stage_pipe #(
    parameter int DATA_W    = 16,
    parameter bit BYPASS_EN = 1'b1,
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [DATA_W-1:0] if_pc_plus2,
    input  logic [2:0]        flags,
    input  logic              wb_we,
    input  logic [3:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              mem_rd_we,
    input  logic [3:0]        mem_rd,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_rd,
    output logic [3:0]        ex_rs,
    output logic [3:0]        ex_rt,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_alu_src,
    output logic              ex_flag_we,
    output logic              ex_pcs,
    output logic              ex_halt,
    output logic [DATA_W-1:0] ex_pc_plus2
);

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef struct packed {
        logic              valid;
        logic [3:0]        opcode;
        logic [DATA_W-1:0] rsData;
        logic [DATA_W-1:0] rtData;
        logic [DATA_W-1:0] imm;
        logic [3:0]        rd;
        logic [3:0]        rs;
        logic [3:0]        rt;
        logic              memRead;
        logic              memWrite;
        logic              regWrite;
        logic              aluSrc;
        logic              flagWe;
        logic              pcs;
        logic              halt;
        logic [DATA_W-1:0] pcPlus2;
    } idEx_t;

    // R0 is hardwired to zero. A same-cycle WB write is forwarded only when
    // bypass is enabled.
    function automatic logic [DATA_W-1:0] readPort(
        input logic [3:0]        addr,
        input logic [DATA_W-1:0] stored,
        input logic              wrEn,
        input logic [3:0]        wrAddr,
        input logic [DATA_W-1:0] wrData
    );
        logic [DATA_W-1:0] val;
        if (addr == 4'd0) begin
            val = '0;
        end else if (BYPASS_EN && wrEn && (wrAddr == addr)) begin
            val = wrData;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    logic [DATA_W-1:0] regFile_r [16];
    idEx_t             idEx_r;
    idEx_t             decoded_s;

    logic [3:0]        opcode_s;
    logic [3:0]        decRs_s;
    logic [3:0]        decRt_s;
    logic [3:0]        decRd_s;
    logic [DATA_W-1:0] decImm_s;
    logic              useRs_s;
    logic              useRt_s;
    logic              wrEn_s;
    logic              aluSrc_s;
    logic              memRead_s;
    logic              memWrite_s;
    logic              pcs_s;
    logic              halt_s;
    logic              flagWe_s;
    logic [DATA_W-1:0] rsData_s;
    logic [DATA_W-1:0] rtData_s;
    logic              isBranch_s;
    logic              condMet_s;
    logic              flagZ_s;
    logic              flagV_s;
    logic              flagN_s;
    logic              loadUse_s;
    logic              flagHaz_s;
    logic              brRegHaz_s;
    logic              hazard_s;
    logic              stall_s;

    assign opcode_s = if_instr[15:12];
    assign flagZ_s  = flags[2];
    assign flagV_s  = flags[1];
    assign flagN_s  = flags[0];

    // Register file write port; R0 is never written and everything clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regFile_r[i] <= '0;
            end
        end else if (wb_we && (wb_addr != 4'd0)) begin
            regFile_r[wb_addr] <= wb_data;
        end
    end

    // Instruction field extraction and control decode.
    always_comb begin
        decRd_s    = if_instr[11:8];
        decRs_s    = if_instr[7:4];
        decRt_s    = 4'd0;
        decImm_s   = '0;
        useRs_s    = 1'b0;
        useRt_s    = 1'b0;
        wrEn_s     = 1'b0;
        aluSrc_s   = 1'b0;
        memRead_s  = 1'b0;
        memWrite_s = 1'b0;
        pcs_s      = 1'b0;
        halt_s     = 1'b0;
        case (opcode_s)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                decRt_s = if_instr[3:0];
                useRs_s = 1'b1;
                useRt_s = 1'b1;
                wrEn_s  = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                decRt_s  = if_instr[3:0];
                decImm_s = {{(DATA_W-4){1'b0}}, if_instr[3:0]};
                useRs_s  = 1'b1;
                aluSrc_s = 1'b1;
                wrEn_s   = 1'b1;
            end
            OP_LW: begin
                decRt_s   = if_instr[11:8];
                decImm_s  = {{(DATA_W-5){if_instr[3]}}, if_instr[3:0], 1'b0};
                useRs_s   = 1'b1;
                aluSrc_s  = 1'b1;
                memRead_s = 1'b1;
                wrEn_s    = 1'b1;
            end
            OP_SW: begin
                decRt_s    = if_instr[11:8];
                decImm_s   = {{(DATA_W-5){if_instr[3]}}, if_instr[3:0], 1'b0};
                useRs_s    = 1'b1;
                useRt_s    = 1'b1;
                aluSrc_s   = 1'b1;
                memWrite_s = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                decRs_s  = if_instr[11:8];
                decImm_s = {{(DATA_W-8){1'b0}}, if_instr[7:0]};
                useRs_s  = 1'b1;
                aluSrc_s = 1'b1;
                wrEn_s   = 1'b1;
            end
            OP_BR: begin
                useRs_s = 1'b1;
            end
            OP_PCS: begin
                wrEn_s = 1'b1;
                pcs_s  = 1'b1;
            end
            OP_HLT: begin
                halt_s = 1'b1;
            end
            default: begin
                useRs_s = 1'b0;
            end
        endcase
    end

    assign flagWe_s   = (opcode_s == OP_ADD) || (opcode_s == OP_SUB) || (opcode_s == OP_XOR);
    assign isBranch_s = (opcode_s == OP_B) || (opcode_s == OP_BR);
    assign rsData_s   = readPort(decRs_s, regFile_r[decRs_s], wb_we, wb_addr, wb_data);
    assign rtData_s   = readPort(decRt_s, regFile_r[decRt_s], wb_we, wb_addr, wb_data);

    // Assemble the candidate ID/EX entry for the current instruction.
    always_comb begin
        decoded_s          = '0;
        decoded_s.valid    = 1'b1;
        decoded_s.opcode   = opcode_s;
        decoded_s.rsData   = rsData_s;
        decoded_s.rtData   = rtData_s;
        decoded_s.imm      = decImm_s;
        decoded_s.rd       = decRd_s;
        decoded_s.rs       = decRs_s;
        decoded_s.rt       = decRt_s;
        decoded_s.memRead  = memRead_s;
        decoded_s.memWrite = memWrite_s;
        decoded_s.regWrite = wrEn_s && (decRd_s != 4'd0);
        decoded_s.aluSrc   = aluSrc_s;
        decoded_s.flagWe   = flagWe_s;
        decoded_s.pcs      = pcs_s;
        decoded_s.halt     = halt_s;
        decoded_s.pcPlus2  = if_pc_plus2;
    end

    // Branch condition evaluation on {Z,V,N}.
    always_comb begin
        condMet_s = 1'b0;
        case (if_instr[11:9])
            3'b000:  condMet_s = !flagZ_s;
            3'b001:  condMet_s = flagZ_s;
            3'b010:  condMet_s = !flagZ_s && !flagN_s;
            3'b011:  condMet_s = flagN_s;
            3'b100:  condMet_s = flagZ_s || (!flagZ_s && !flagN_s);
            3'b101:  condMet_s = flagN_s || flagZ_s;
            3'b110:  condMet_s = flagV_s;
            3'b111:  condMet_s = 1'b1;
            default: condMet_s = 1'b0;
        endcase
    end

    // Hazard detection against the ID/EX entry and the EX/MEM destination.
    always_comb begin
        loadUse_s = idEx_r.valid && idEx_r.memRead && (idEx_r.rd != 4'd0) &&
                    ((useRs_s && (idEx_r.rd == decRs_s)) ||
                     (useRt_s && (idEx_r.rd == decRt_s)));
        flagHaz_s = idEx_r.valid && idEx_r.flagWe && isBranch_s &&
                    (if_instr[11:9] != 3'b111);
        brRegHaz_s = (opcode_s == OP_BR) && (if_instr[7:4] != 4'd0) &&
                     ((idEx_r.regWrite && (idEx_r.rd == if_instr[7:4])) ||
                      (mem_rd_we && (mem_rd == if_instr[7:4])));
        if (HAZARD_EN) begin
            hazard_s = loadUse_s || flagHaz_s || brRegHaz_s;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign stall_s       = ex_hold || (if_valid && hazard_s);
    assign id_stall      = stall_s;
    assign branch_taken  = !rst && if_valid && !stall_s && isBranch_s && condMet_s;
    assign branch_target = (opcode_s == OP_BR) ? rsData_s
                         : (if_pc_plus2 + {{(DATA_W-10){if_instr[8]}}, if_instr[8:0], 1'b0});

    // ID/EX boundary: reset, then hold, then bubble, then load.
    always_ff @(posedge clk) begin
        if (rst) begin
            idEx_r <= '0;
        end else if (ex_hold) begin
            idEx_r <= idEx_r;
        end else if (hazard_s || !if_valid) begin
            idEx_r <= '0;
        end else begin
            idEx_r <= decoded_s;
        end
    end

    assign ex_valid     = idEx_r.valid;
    assign ex_opcode    = idEx_r.opcode;
    assign ex_rs_data   = idEx_r.rsData;
    assign ex_rt_data   = idEx_r.rtData;
    assign ex_imm       = idEx_r.imm;
    assign ex_rd        = idEx_r.rd;
    assign ex_rs        = idEx_r.rs;
    assign ex_rt        = idEx_r.rt;
    assign ex_mem_read  = idEx_r.memRead;
    assign ex_mem_write = idEx_r.memWrite;
    assign ex_reg_write = idEx_r.regWrite;
    assign ex_alu_src   = idEx_r.aluSrc;
    assign ex_flag_we   = idEx_r.flagWe;
    assign ex_pcs       = idEx_r.pcs;
    assign ex_halt      = idEx_r.halt;
    assign ex_pc_plus2  = idEx_r.pcPlus2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: one instance with WB bypass and one
// without, both driven identically and checked against a reference model.
module tb_id_stage_pipe;

    typedef struct packed {
        logic        valid;
        logic [3:0]  opcode;
        logic [15:0] rsData;
        logic [15:0] rtData;
        logic [15:0] imm;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        aluSrc;
        logic        flagWe;
        logic        pcs;
        logic        halt;
        logic [15:0] pcPlus2;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifValid = 1'b0;
    logic [15:0] ifInstr = 16'h0000;
    logic [15:0] ifPc = 16'h0000;
    logic [2:0]  flags = 3'b000;
    logic        wbWe = 1'b0;
    logic [3:0]  wbAddr = 4'd0;
    logic [15:0] wbData = 16'h0000;
    logic        memRdWe = 1'b0;
    logic [3:0]  memRd = 4'd0;
    logic        exHold = 1'b0;

    logic idStall1, brTaken1, exValid1, exMemRead1, exMemWrite1, exRegWrite1;
    logic exAluSrc1, exFlagWe1, exPcs1, exHalt1;
    logic [15:0] brTarget1, exRsData1, exRtData1, exImm1, exPc1;
    logic [3:0]  exOpcode1, exRd1, exRs1, exRt1;
    logic idStall0, brTaken0, exValid0, exMemRead0, exMemWrite0, exRegWrite0;
    logic exAluSrc0, exFlagWe0, exPcs0, exHalt0;
    logic [15:0] brTarget0, exRsData0, exRtData0, exImm0, exPc0;
    logic [3:0]  exOpcode0, exRd0, exRs0, exRt0;

    ent_t d1, d0;
    assign d1 = {exValid1, exOpcode1, exRsData1, exRtData1, exImm1, exRd1, exRs1, exRt1,
                 exMemRead1, exMemWrite1, exRegWrite1, exAluSrc1, exFlagWe1, exPcs1, exHalt1, exPc1};
    assign d0 = {exValid0, exOpcode0, exRsData0, exRtData0, exImm0, exRd0, exRs0, exRt0,
                 exMemRead0, exMemWrite0, exRegWrite0, exAluSrc0, exFlagWe0, exPcs0, exHalt0, exPc0};

    id_stage_pipe #(.DATA_W(16), .BYPASS_EN(1'b1), .HAZARD_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .if_valid(ifValid), .if_instr(ifInstr), .if_pc_plus2(ifPc),
        .flags(flags), .wb_we(wbWe), .wb_addr(wbAddr), .wb_data(wbData),
        .mem_rd_we(memRdWe), .mem_rd(memRd), .ex_hold(exHold),
        .id_stall(idStall1), .branch_taken(brTaken1), .branch_target(brTarget1),
        .ex_valid(exValid1), .ex_opcode(exOpcode1), .ex_rs_data(exRsData1), .ex_rt_data(exRtData1),
        .ex_imm(exImm1), .ex_rd(exRd1), .ex_rs(exRs1), .ex_rt(exRt1), .ex_mem_read(exMemRead1),
        .ex_mem_write(exMemWrite1), .ex_reg_write(exRegWrite1), .ex_alu_src(exAluSrc1),
        .ex_flag_we(exFlagWe1), .ex_pcs(exPcs1), .ex_halt(exHalt1), .ex_pc_plus2(exPc1));

    id_stage_pipe #(.DATA_W(16), .BYPASS_EN(1'b0), .HAZARD_EN(1'b1)) u_dut_nb (
        .clk(clk), .rst(rst), .if_valid(ifValid), .if_instr(ifInstr), .if_pc_plus2(ifPc),
        .flags(flags), .wb_we(wbWe), .wb_addr(wbAddr), .wb_data(wbData),
        .mem_rd_we(memRdWe), .mem_rd(memRd), .ex_hold(exHold),
        .id_stall(idStall0), .branch_taken(brTaken0), .branch_target(brTarget0),
        .ex_valid(exValid0), .ex_opcode(exOpcode0), .ex_rs_data(exRsData0), .ex_rt_data(exRtData0),
        .ex_imm(exImm0), .ex_rd(exRd0), .ex_rs(exRs0), .ex_rt(exRt0), .ex_mem_read(exMemRead0),
        .ex_mem_write(exMemWrite0), .ex_reg_write(exRegWrite0), .ex_alu_src(exAluSrc0),
        .ex_flag_we(exFlagWe0), .ex_pcs(exPcs0), .ex_halt(exHalt0), .ex_pc_plus2(exPc0));

    always #5 clk = ~clk;

    int          nVec = 0;
    int          nMis = 0;
    ent_t        q1[$];
    ent_t        q0[$];
    ent_t        mEx1 = '0;
    ent_t        mEx0 = '0;
    logic [15:0] mRegs [16];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Architectural register read as seen by ID.
    function automatic logic [15:0] rdReg(input logic [3:0] a, input bit byp);
        if (a == 4'd0) return 16'h0000;
        if (byp && wbWe && wbAddr == a) return wbData;
        return mRegs[a];
    endfunction

    function automatic ent_t decode(input logic [15:0] ins, input logic [15:0] pc, input bit byp);
        ent_t e;
        int   op;
        int   off;
        op = int'(ins[15:12]);
        e = '0;
        e.valid = 1'b1;
        e.opcode = ins[15:12];
        e.pcPlus2 = pc;
        e.rd = ins[11:8];
        e.rs = (op == 10 || op == 11) ? ins[11:8] : ins[7:4];
        e.rt = (op <= 7) ? ins[3:0] : (op == 8 || op == 9) ? ins[11:8] : 4'd0;
        if (op >= 4 && op <= 6) e.imm = {12'h000, ins[3:0]};
        if (op == 8 || op == 9) begin
            off = $signed(ins[3:0]);
            e.imm = 16'(off * 2);
        end
        if (op == 10 || op == 11) e.imm = {8'h00, ins[7:0]};
        e.aluSrc = (op >= 4 && op <= 6) || (op >= 8 && op <= 11);
        e.memRead = (op == 8);
        e.memWrite = (op == 9);
        e.regWrite = (op <= 8 || op == 10 || op == 11 || op == 14) && (ins[11:8] != 4'd0);
        e.flagWe = (op <= 2);
        e.pcs = (op == 14);
        e.halt = (op == 15);
        e.rsData = rdReg(e.rs, byp);
        e.rtData = rdReg(e.rt, byp);
        return e;
    endfunction

    function automatic logic hazardOf(input logic [15:0] ins);
        logic [3:0] src[$];
        int         op;
        logic       lu, fh, bh;
        op = int'(ins[15:12]);
        if (op <= 3 || op == 7) begin src.push_back(ins[7:4]); src.push_back(ins[3:0]); end
        else if ((op >= 4 && op <= 6) || op == 8 || op == 13) src.push_back(ins[7:4]);
        else if (op == 9) begin src.push_back(ins[7:4]); src.push_back(ins[11:8]); end
        else if (op == 10 || op == 11) src.push_back(ins[11:8]);
        lu = 1'b0;
        if (mEx1.valid && mEx1.memRead && mEx1.rd != 4'd0)
            foreach (src[i]) if (src[i] == mEx1.rd) lu = 1'b1;
        fh = mEx1.valid && mEx1.flagWe && (op == 12 || op == 13) && ins[11:9] != 3'b111;
        bh = (op == 13) && ins[7:4] != 4'd0 &&
             ((mEx1.regWrite && mEx1.rd == ins[7:4]) || (memRdWe && memRd == ins[7:4]));
        return lu || fh || bh;
    endfunction

    function automatic logic condOk(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        {z, v, n} = f;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // One clock: check combinational outputs, queue the expected ID/EX, advance model.
    task automatic cyc();
        logic hz, stl, tk, isBr;
        int   off;
        logic [15:0] tgt1, tgt0;
        ent_t n1, n0;
        #1;
        hz = hazardOf(ifInstr);
        stl = exHold || (ifValid && hz);
        isBr = (ifInstr[15:12] == 4'hC) || (ifInstr[15:12] == 4'hD);
        tk = !rst && ifValid && !stl && isBr && condOk(ifInstr[11:9], flags);
        chk("id_stall", idStall1, stl);
        chk("id_stall_nb", idStall0, stl);
        chk("branch_taken", brTaken1, tk);
        chk("branch_taken_nb", brTaken0, tk);
        if (tk) begin
            off = $signed(ifInstr[8:0]);
            tgt1 = (ifInstr[15:12] == 4'hD) ? rdReg(ifInstr[7:4], 1'b1) : 16'(int'(ifPc) + off * 2);
            tgt0 = (ifInstr[15:12] == 4'hD) ? rdReg(ifInstr[7:4], 1'b0) : tgt1;
            chk("branch_target", brTarget1, tgt1);
            chk("branch_target_nb", brTarget0, tgt0);
        end
        if (rst) begin n1 = '0; n0 = '0; end
        else if (exHold) begin n1 = mEx1; n0 = mEx0; end
        else if (hz || !ifValid) begin n1 = '0; n0 = '0; end
        else begin n1 = decode(ifInstr, ifPc, 1'b1); n0 = decode(ifInstr, ifPc, 1'b0); end
        q1.push_back(n1);
        q0.push_back(n0);
        mEx1 = n1;
        mEx0 = n0;
        if (rst) foreach (mRegs[i]) mRegs[i] = 16'h0000;
        else if (wbWe && wbAddr != 4'd0) mRegs[wbAddr] = wbData;
        @(negedge clk);
    endtask

    // Monitor: every clock the ID/EX register presents a new state.
    always @(posedge clk) begin
        ent_t e;
        #1;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("idex", d1, e);
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("idex_nb", d0, e);
        end
    end

    task automatic setIns(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        ifValid = v;
        ifInstr = ins;
        ifPc = pc;
    endtask

    initial begin
        logic [31:0] r;
        foreach (mRegs[i]) mRegs[i] = 16'h0000;
        @(negedge clk);
        cyc();
        chk("reset_valid", exValid1, 1'b0);
        rst = 1'b0;
        wbWe = 1'b1; wbAddr = 4'd1; wbData = 16'd5; cyc();
        wbAddr = 4'd2; wbData = 16'd7; cyc();
        wbWe = 1'b0;
        // ADD R3,R1,R2
        setIns(1'b1, 16'h0312, 16'h0010); cyc();
        chk("add_valid", exValid1, 1'b1);
        chk("add_rs", exRsData1, 16'd5);
        chk("add_rt", exRtData1, 16'd7);
        chk("add_rd", exRd1, 4'd3);
        chk("add_fwe", exFlagWe1, 1'b1);
        // LW R4,[R1+3] then ADD R5,R4,R2
        setIns(1'b1, 16'h8413, 16'h0012); cyc();
        chk("lw_imm", exImm1, 16'd6);
        setIns(1'b1, 16'h0542, 16'h0014); #1;
        chk("lu_stall", idStall1, 1'b1);
        cyc();
        chk("lu_bubble", exValid1, 1'b0);
        chk("lu_release", idStall1, 1'b0);
        cyc();
        chk("lu_issue", exRd1, 4'd5);
        // SUB then B cond=001 with Z=1
        setIns(1'b1, 16'h1112, 16'h0016); cyc();
        flags = 3'b100;
        setIns(1'b1, 16'hC205, 16'h0100); #1;
        chk("fl_stall", idStall1, 1'b1);
        cyc();
        chk("br_taken", brTaken1, 1'b1);
        chk("br_target", brTarget1, 16'h010A);
        cyc();
        // Same-cycle WB of R6 with an ID read of R6
        wbWe = 1'b1; wbAddr = 4'd6; wbData = 16'h1234;
        setIns(1'b1, 16'h0760, 16'h0102); cyc();
        wbWe = 1'b0;
        chk("bypass_on", exRsData1, 16'h1234);
        chk("bypass_off", exRsData0, 16'h0000);
        // Downstream hold for three cycles
        exHold = 1'b1;
        setIns(1'b1, 16'hCE04, 16'h0104);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_stall", idStall1, 1'b1);
            chk("hold_taken", brTaken1, 1'b0);
            cyc();
        end
        exHold = 1'b0; cyc();
        // Reset during a load-use stall, then R0 write
        setIns(1'b1, 16'h8413, 16'h0200); cyc();
        setIns(1'b1, 16'h0542, 16'h0202); rst = 1'b1; cyc();
        chk("rst_clear", d1, 0);
        rst = 1'b0;
        wbWe = 1'b1; wbAddr = 4'd0; wbData = 16'hFFFF;
        setIns(1'b1, 16'h0100, 16'h0204); cyc();
        wbWe = 1'b0;
        chk("post_rst_accept", exValid1, 1'b1);
        setIns(1'b1, 16'h0200, 16'h0206); cyc();
        chk("r0_zero", exRsData1, 16'h0000);
        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            exHold = ($urandom_range(0, 9) == 0);
            r = $urandom;
            if ($urandom_range(0, 2) != 0) r[15:0] = r[15:0] & 16'hF333;
            setIns($urandom_range(0, 9) < 8, r[15:0], r[31:16]);
            r = $urandom;
            flags = r[2:0];
            wbWe = r[3];
            wbAddr = r[4] ? r[8:5] : {2'b00, r[6:5]};
            wbData = r[31:16];
            memRdWe = r[9];
            memRd = {2'b00, r[11:10]};
            cyc();
        end
        rst = 1'b0; exHold = 1'b0; ifValid = 1'b0; wbWe = 1'b0; memRdWe = 1'b0;
        cyc();
        #2;
        chk("drain", q1.size() + q0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
